// File: rtl/led_7seg_mux_counter.sv
// Multi-digit BCD up/down counter with a prescaled step and a time-multiplexed
// 7-segment drive. It has one shared segment bus and one select line per digit.
module led_7seg_mux_counter #(
    parameter int NUM_DIGITS      = 4,
    parameter int PRESCALE        = 133_000_000,
    parameter int SCAN_DIV        = 133_000,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int DIG_ACTIVE_HIGH = 0,
    parameter int LZB             = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig
);

    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_HIGH != 0) ?
                                                {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};

    logic [PW-1:0]           pre_cnt;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           scan_idx;
    logic                    tick;
    logic                    carry;
    logic [3:0]              cur_d;
    logic [4*NUM_DIGITS-1:0] count_step;
    logic [4*NUM_DIGITS-1:0] load_sat;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              sel_digit;
    logic                    sel_dp;
    logic                    sel_blank;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [7:0]              glyph;
    logic [7:0]              seg_raw;

    function automatic logic [7:0] seg_table(input logic [3:0] d);
        case (d)
            4'd0:    seg_table = 8'hFC;
            4'd1:    seg_table = 8'h60;
            4'd2:    seg_table = 8'hDA;
            4'd3:    seg_table = 8'hF2;
            4'd4:    seg_table = 8'h66;
            4'd5:    seg_table = 8'hB6;
            4'd6:    seg_table = 8'hBE;
            4'd7:    seg_table = 8'hE0;
            4'd8:    seg_table = 8'hFE;
            4'd9:    seg_table = 8'hF6;
            default: seg_table = 8'h00;
        endcase
    endfunction

    assign tick = en && (pre_cnt == PRE_MAX);

    // The carry ripples only while lower digits roll over. The final carry marks a full-chain wrap.
    always_comb begin
        carry      = 1'b1;
        cur_d      = 4'd0;
        count_step = count;
        load_sat   = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cur_d = count[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (cur_d == 4'd9) begin
                        count_step[4*i +: 4] = 4'd0;
                    end else begin
                        count_step[4*i +: 4] = cur_d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (cur_d == 4'd0) begin
                        count_step[4*i +: 4] = 4'd9;
                    end else begin
                        count_step[4*i +: 4] = cur_d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            if (load_val[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            count   <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count   <= load_sat;
                pre_cnt <= '0;
            end else if (tick) begin
                count   <= count_step;
                pre_cnt <= '0;
                wrap    <= carry;
            end else if (en) begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero. Digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (count[4*i +: 4] == 4'd0);
            blank[i] = (LZB != 0) && zero_run;
        end
    end

    always_comb begin
        sel_digit = 4'd0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        dig_sel   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                sel_digit  = count[4*i +: 4];
                sel_dp     = dp[i];
                sel_blank  = blank[i];
                dig_sel[i] = 1'b1;
            end
        end
        glyph   = sel_blank ? 8'h00 : seg_table(sel_digit);
        seg_raw = {glyph[7:1], sel_dp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            seg      <= SEG_OFF;
            dig      <= DIG_OFF;
        end else begin
            seg <= (SEG_ACTIVE_HIGH != 0) ? seg_raw : ~seg_raw;
            dig <= (DIG_ACTIVE_HIGH != 0) ? dig_sel : ~dig_sel;
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_7seg_mux_counter.sv
// Directed bench for led_7seg_mux_counter with 2 digits, a prescale of 4 and a scan divider of 2.
// Inputs change 1 ns after each rising edge, and outputs are sampled at that same point.
module tb_led_7seg_mux_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [1:0] dp;
    logic [7:0] count;
    logic       wrap;
    logic [7:0] seg;
    logic [1:0] dig;

    int checks   = 0;
    int failures = 0;

    led_7seg_mux_counter #(
        .NUM_DIGITS(2), .PRESCALE(4), .SCAN_DIV(2),
        .SEG_ACTIVE_HIGH(1), .DIG_ACTIVE_HIGH(1), .LZB(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .dp(dp), .count(count), .wrap(wrap), .seg(seg), .dig(dig)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00; dp = 2'b00;
        #2 rst_n = 1'b0;
        step(2);
        checks++;
        if (count !== 8'h00 || wrap !== 1'b0 || seg !== 8'h00 || dig !== 2'b00) begin
            failures++;
            $display("FAIL reset: count=%h wrap=%b seg=%h dig=%b, want 00 0 00 00", count, wrap, seg, dig);
        end
        #2 rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_count_up;
        logic [7:0] exp_seq [8] = '{8'h99, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        logic [7:0] prev;
        en = 1'b1; up_dn = 1'b1;
        do_load(8'h98);
        prev = 8'h98;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 3; c++) begin
                step(1);
                checks++;
                if (count !== prev || wrap !== 1'b0) begin
                    failures++;
                    $display("FAIL up_hold k=%0d c=%0d: count=%h wrap=%b, want %h 0", k, c, count, wrap, prev);
                end
            end
            step(1);
            checks++;
            if (count !== exp_seq[k] || wrap !== (k == 1)) begin
                failures++;
                $display("FAIL up_tick k=%0d: count=%h wrap=%b, want %h %b", k, count, wrap, exp_seq[k], (k == 1));
            end
            prev = exp_seq[k];
        end
    endtask

    task automatic test_count_down_and_load_sat;
        en = 1'b1; up_dn = 1'b0;
        do_load(8'h00);
        step(3);
        checks++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL down_pre: count=%h wrap=%b, want 00 0", count, wrap);
        end
        step(1);
        checks++;
        if (count !== 8'h99 || wrap !== 1'b1) begin
            failures++;
            $display("FAIL down_wrap: count=%h wrap=%b, want 99 1", count, wrap);
        end
        step(1);
        checks++;
        if (wrap !== 1'b0) begin
            failures++;
            $display("FAIL down_wrap_len: wrap=%b, want 0", wrap);
        end
        do_load(8'hFA);
        checks++;
        if (count !== 8'h99 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_sat: count=%h wrap=%b, want 99 0", count, wrap);
        end
    endtask

    task automatic test_enable_freeze;
        bit seen0, seen1;
        seen0 = 1'b0; seen1 = 1'b0;
        en = 1'b1; up_dn = 1'b1;
        do_load(8'h12);
        step(2);
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (dig == 2'b01) seen0 = 1'b1;
            if (dig == 2'b10) seen1 = 1'b1;
            checks++;
            if (count !== 8'h12 || (dig !== 2'b01 && dig !== 2'b10)) begin
                failures++;
                $display("FAIL freeze c=%0d: count=%h dig=%b, want 12 one-hot", c, count, dig);
            end
        end
        checks++;
        if (!(seen0 && seen1)) begin
            failures++;
            $display("FAIL freeze_scan: seen dig01=%b dig10=%b, want 1 1", seen0, seen1);
        end
        en = 1'b1;
        step(1);
        checks++;
        if (count !== 8'h12) begin
            failures++;
            $display("FAIL resume_early: count=%h, want 12", count);
        end
        step(1);
        checks++;
        if (count !== 8'h13) begin
            failures++;
            $display("FAIL resume_tick: count=%h, want 13", count);
        end
    endtask

    task automatic test_scan_blank;
        int n0, n1;
        en = 1'b0; dp = 2'b10;
        do_load(8'h05);
        step(2);
        n0 = 0; n1 = 0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            checks++;
            if (dig == 2'b01) begin
                n0++;
                if (seg !== 8'hB6) begin
                    failures++;
                    $display("FAIL scan05_d0 c=%0d: seg=%h, want b6", c, seg);
                end
            end else if (dig == 2'b10) begin
                n1++;
                if (seg !== 8'h01) begin
                    failures++;
                    $display("FAIL scan05_d1 c=%0d: seg=%h, want 01", c, seg);
                end
            end else begin
                failures++;
                $display("FAIL scan05_dig c=%0d: dig=%b, want 01 or 10", c, dig);
            end
        end
        checks++;
        if (n0 == 0 || n1 == 0) begin
            failures++;
            $display("FAIL scan05_cover: d0=%0d d1=%0d, want both >0", n0, n1);
        end
        dp = 2'b00;
        do_load(8'h50);
        step(2);
        for (int c = 0; c < 8; c++) begin
            step(1);
            checks++;
            if (!((dig == 2'b01 && seg == 8'hFC) || (dig == 2'b10 && seg == 8'hB6))) begin
                failures++;
                $display("FAIL scan50 c=%0d: dig=%b seg=%h, want 01/fc or 10/b6", c, dig, seg);
            end
        end
    endtask

    task automatic test_load_vs_tick;
        en = 1'b1; up_dn = 1'b1;
        do_load(8'h99);
        step(3);
        do_load(8'h37);
        checks++;
        if (count !== 8'h37 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_tick: count=%h wrap=%b, want 37 0", count, wrap);
        end
        step(3);
        checks++;
        if (count !== 8'h37) begin
            failures++;
            $display("FAIL load_tick_hold: count=%h, want 37", count);
        end
        step(1);
        checks++;
        if (count !== 8'h38) begin
            failures++;
            $display("FAIL load_tick_next: count=%h, want 38", count);
        end
        step(2);
        do_load(8'h20);
        step(3);
        checks++;
        if (count !== 8'h20) begin
            failures++;
            $display("FAIL load_clr_pre: count=%h, want 20", count);
        end
        step(1);
        checks++;
        if (count !== 8'h21) begin
            failures++;
            $display("FAIL load_clr_next: count=%h, want 21", count);
        end
    endtask

    task automatic test_async_reset;
        dp = 2'b11; en = 1'b1;
        step(5);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 8'h00 || wrap !== 1'b0 || seg !== 8'h00 || dig !== 2'b00) begin
            failures++;
            $display("FAIL async_reset: count=%h wrap=%b seg=%h dig=%b, want 00 0 00 00", count, wrap, seg, dig);
        end
        step(2);
        #2 rst_n = 1'b1;
        step(1);
        checks++;
        if (count !== 8'h00 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: count=%h wrap=%b, want 00 0", count, wrap);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down_and_load_sat();
        test_enable_freeze();
        test_scan_blank();
        test_load_vs_tick();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
